radix4_mac_acc: RTL and testbench



---
 rtl/radix4_mac_acc.sv | 127 ++++++++++++
 tb/tb_radix4_mac_acc.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/radix4_mac_acc.sv
// Accumulates a programmed number of signed radix-4 Booth products into a guarded
// accumulator, then reports the sum with a one-cycle valid pulse and an overflow flag.
module radix4_mac_acc #(
   parameter int WIDTH = 32,
   parameter int GUARD = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [CNT_W-1:0]           len,
   input  logic                       nd,
   input  logic [2*WIDTH-1:0]         q,
   output logic                       ready,
   output logic                       busy,
   output logic                       valid,
   output logic [2*WIDTH+GUARD-1:0]   acc_out,
   output logic                       ovf,
   output logic [CNT_W-1:0]           count,
   output logic [1:0]                 dbg_state
);

   localparam int PW = 2 * WIDTH;
   localparam int AW = PW + GUARD;

   // Handshake: a run is accepted on a rising edge where ready=1 and start=1.
   // Inside a run, q is consumed on every rising edge where busy=1 and nd=1;
   // there is no back-pressure. valid=1 marks the single cycle acc_out is final.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] cnt_q;
   logic [AW-1:0]    acc_q;
   logic             ovf_q;
   logic             ready_q;
   logic             busy_q;
   logic             valid_q;

   logic [AW-1:0]    q_ext;
   logic [AW-1:0]    acc_d;
   logic             ovf_d;

   // True when bits [AW-1:PW-1] are all equal, i.e. the value fits in PW signed bits.
   function automatic logic fits_signed(input logic [AW-1:0] a);
      logic [GUARD:0] top;
      top = a[AW-1:PW-1];
      return (&top) | (~|top);
   endfunction

   always_comb begin
      q_ext = {{GUARD{q[PW-1]}}, q};
      acc_d = acc_q + q_ext;
      ovf_d = ~fits_signed(acc_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         rem_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               valid_q <= 1'b0;
               if (start) begin
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  ovf_q   <= 1'b0;
                  rem_q   <= len;
                  ready_q <= 1'b0;
                  if (len == '0) begin
                     // An empty run still produces a (zero) result pulse.
                     state_q <= S_DONE;
                     valid_q <= 1'b1;
                  end else begin
                     state_q <= S_ACC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_ACC: begin
               if (nd) begin
                  acc_q <= acc_d;
                  cnt_q <= cnt_q + CNT_W'(1);
                  rem_q <= rem_q - CNT_W'(1);
                  if (rem_q == CNT_W'(1)) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     valid_q <= 1'b1;
                     ovf_q   <= ovf_d;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
            default: begin
               state_q <= S_IDLE;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready     = ready_q;
   assign busy      = busy_q;
   assign valid     = valid_q;
   assign acc_out   = acc_q;
   assign ovf       = ovf_q;
   assign count     = cnt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_radix4_mac_acc.sv
// Directed bench for radix4_mac_acc: each scenario task drives a run and checks
// the result, latency, flags and valid pulse count against hand-computed values.
`timescale 1ns/1ps
module tb_radix4_mac_acc;

   localparam int WIDTH = 32;
   localparam int GUARD = 8;
   localparam int CNT_W = 16;
   localparam int PW = 2 * WIDTH;
   localparam int AW = PW + GUARD;

   logic             clk;
   logic             reset;
   logic             start;
   logic [CNT_W-1:0] len;
   logic             nd;
   logic [PW-1:0]    q;
   logic             ready;
   logic             busy;
   logic             valid;
   logic [AW-1:0]    acc_out;
   logic             ovf;
   logic [CNT_W-1:0] count;
   logic [1:0]       dbg_state;

   int tests;
   int fails;
   int pulses;
   logic [PW-1:0] qv[$];
   logic [AW-1:0] exp_q[$];

   radix4_mac_acc #(.WIDTH(WIDTH), .GUARD(GUARD), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start), .len(len), .nd(nd), .q(q),
      .ready(ready), .busy(busy), .valid(valid), .acc_out(acc_out),
      .ovf(ovf), .count(count), .dbg_state(dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) if (valid === 1'b1) pulses++;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // driver: starts a run of length l and feeds qv on consecutive cycles;
   // returns sampled just after the edge that accepted the last nd
   task automatic drive_run(input logic [CNT_W-1:0] l);
      start = 1'b1;
      len   = l;
      step();
      start = 1'b0;
      foreach (qv[i]) begin
         nd = 1'b1;
         q  = qv[i];
         step();
      end
      nd = 1'b0;
      q  = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0b want 1", ready); end
      tests++; if (busy !== 1'b0 || valid !== 1'b0) begin fails++; $display("FAIL reset_busy_valid got %0b/%0b want 0/0", busy, valid); end
      tests++; if (acc_out !== '0 || count !== '0 || ovf !== 1'b0) begin fails++; $display("FAIL reset_regs got acc=%0h cnt=%0d ovf=%0b want 0", acc_out, count, ovf); end
      tests++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state got %0d want 0", dbg_state); end
   endtask

   task automatic test_baseline();
      int p0;
      p0 = pulses;
      qv.delete();
      qv.push_back(64'(200));
      qv.push_back(64'(231));
      qv.push_back(64'(231));
      qv.push_back(64'(-231));
      qv.push_back(64'(-231));
      drive_run(16'd5);
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL base_valid got %0b want 1", valid); end
      tests++; if (acc_out !== 72'd200) begin fails++; $display("FAIL base_acc got %0h want c8", acc_out); end
      tests++; if (count !== 16'd5 || ovf !== 1'b0) begin fails++; $display("FAIL base_cnt_ovf got %0d/%0b want 5/0", count, ovf); end
      step();
      tests++; if (valid !== 1'b0 || ready !== 1'b1) begin fails++; $display("FAIL base_after got valid=%0b ready=%0b want 0/1", valid, ready); end
      step();
      step();
      tests++; if (acc_out !== 72'd200 || count !== 16'd5) begin fails++; $display("FAIL base_hold got acc=%0h cnt=%0d want c8/5", acc_out, count); end
      tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL base_pulses got %0d want 1", pulses - p0); end
   endtask

   task automatic test_gapped();
      int p0;
      p0 = pulses;
      start = 1'b1; len = 16'd3;
      step();
      start = 1'b0;
      tests++; if (busy !== 1'b1 || ready !== 1'b0) begin fails++; $display("FAIL gap_busy0 got busy=%0b ready=%0b want 1/0", busy, ready); end
      nd = 1'b1; q = 64'(20000);
      step();
      nd = 1'b0;
      step();
      start = 1'b1; len = 16'd0;
      step();
      start = 1'b0;
      tests++; if (busy !== 1'b1 || count !== 16'd1) begin fails++; $display("FAIL gap_start_ignored got busy=%0b cnt=%0d want 1/1", busy, count); end
      nd = 1'b1; q = 64'(-7);
      step();
      nd = 1'b0;
      step();
      tests++; if (busy !== 1'b1 || valid !== 1'b0) begin fails++; $display("FAIL gap_busy1 got busy=%0b valid=%0b want 1/0", busy, valid); end
      nd = 1'b1; q = 64'(1);
      step();
      nd = 1'b0;
      tests++; if (valid !== 1'b1 || acc_out !== 72'd19994 || count !== 16'd3) begin fails++; $display("FAIL gap_result got v=%0b acc=%0d cnt=%0d want 1/19994/3", valid, acc_out, count); end
      step();
      tests++; if (pulses - p0 !== 1) begin fails++; $display("FAIL gap_pulses got %0d want 1", pulses - p0); end
   endtask

   task automatic test_zero_len_same_cycle();
      qv.delete();
      drive_run(16'd0);
      tests++; if (valid !== 1'b1 || acc_out !== '0 || count !== '0) begin fails++; $display("FAIL zero_len got v=%0b acc=%0h cnt=%0d want 1/0/0", valid, acc_out, count); end
      step();
      tests++; if (ready !== 1'b1 || valid !== 1'b0) begin fails++; $display("FAIL zero_len_after got ready=%0b valid=%0b want 1/0", ready, valid); end
      start = 1'b1; len = 16'd1; nd = 1'b1; q = 64'(99);
      step();
      start = 1'b0; q = 64'(7);
      tests++; if (count !== '0 || acc_out !== '0) begin fails++; $display("FAIL same_cycle_nd got cnt=%0d acc=%0h want 0/0", count, acc_out); end
      step();
      nd = 1'b0;
      tests++; if (valid !== 1'b1 || acc_out !== 72'd7 || count !== 16'd1) begin fails++; $display("FAIL same_cycle_result got v=%0b acc=%0h cnt=%0d want 1/7/1", valid, acc_out, count); end
      step();
   endtask

   task automatic test_overflow();
      qv.delete();
      qv.push_back(64'h7FFF_FFFF_FFFF_FFFF);
      qv.push_back(64'h7FFF_FFFF_FFFF_FFFF);
      drive_run(16'd2);
      tests++; if (acc_out !== 72'h00_FFFF_FFFF_FFFF_FFFE || ovf !== 1'b1) begin fails++; $display("FAIL ovf_pos got acc=%0h ovf=%0b want 00fffffffffffffffe/1", acc_out, ovf); end
      step();
      qv.delete();
      qv.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      qv.push_back(64'hFFFF_FFFF_FFFF_FFFF);
      drive_run(16'd2);
      tests++; if (acc_out !== 72'hFF_FFFF_FFFF_FFFF_FFFE || ovf !== 1'b0) begin fails++; $display("FAIL ovf_neg got acc=%0h ovf=%0b want fffffffffffffffffe/0", acc_out, ovf); end
      step();
   endtask

   task automatic test_reset_mid_run();
      int p0;
      p0 = pulses;
      start = 1'b1; len = 16'd4;
      step();
      start = 1'b0;
      nd = 1'b1; q = 64'(3);
      step();
      step();
      nd = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      tests++; if (ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin fails++; $display("FAIL midrst_state got ready=%0b busy=%0b st=%0d want 1/0/0", ready, busy, dbg_state); end
      tests++; if (acc_out !== '0 || count !== '0) begin fails++; $display("FAIL midrst_regs got acc=%0h cnt=%0d want 0/0", acc_out, count); end
      step();
      step();
      tests++; if (pulses - p0 !== 0) begin fails++; $display("FAIL midrst_pulse got %0d want 0", pulses - p0); end
      qv.delete();
      qv.push_back(64'(5));
      drive_run(16'd1);
      tests++; if (valid !== 1'b1 || acc_out !== 72'd5) begin fails++; $display("FAIL midrst_next got v=%0b acc=%0h want 1/5", valid, acc_out); end
      step();
   endtask

   task automatic test_back_to_back();
      int p0;
      int n;
      logic signed [WIDTH-1:0] a, b;
      logic [PW-1:0] p;
      logic [AW-1:0] e;
      p0 = pulses;
      for (int r = 0; r < 4; r++) begin
         n = $urandom_range(3, 6);
         qv.delete();
         e = '0;
         for (int i = 0; i < n; i++) begin
            a = $urandom();
            b = $urandom();
            p = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
            qv.push_back(p);
            e = e + {{GUARD{p[PW-1]}}, p};
         end
         exp_q.push_back(e);
         tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready run %0d got %0b want 1", r, ready); end
         drive_run(CNT_W'(n));
         e = exp_q.pop_front();
         tests++; if (valid !== 1'b1 || acc_out !== e || count !== CNT_W'(n)) begin fails++; $display("FAIL b2b_result run %0d got v=%0b acc=%0h cnt=%0d want 1/%0h/%0d", r, valid, acc_out, count, e, n); end
         step();
      end
      tests++; if (pulses - p0 !== 4) begin fails++; $display("FAIL b2b_pulses got %0d want 4", pulses - p0); end
   endtask

   initial begin
      tests = 0; fails = 0; pulses = 0;
      reset = 1'b1; start = 1'b0; len = '0; nd = 1'b0; q = '0;
      test_reset();
      test_baseline();
      test_gapped();
      test_zero_len_same_cycle();
      test_overflow();
      test_reset_mid_run();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
